// File: rtl/ms_tick_receiver.sv
// Receives the divided millisecond toggle, emits per-ms ticks, a running ms count,
// programmable beat pulses and a watchdog flag for a stalled tick source.
module ms_tick_receiver #(
    parameter int unsigned TIMEOUT_CYC = 120000,
    parameter int unsigned GAP_W       = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tog_in,
    input  logic        run,
    input  logic        clear,
    input  logic [15:0] beat_ms,
    output logic        ms_tick,
    output logic [31:0] ms_count,
    output logic        beat,
    output logic [15:0] beat_idx,
    output logic        lost
);

    typedef enum logic [1:0] {IDLE, RUN, LOST} state_t;

    state_t           state, state_d;
    logic             s1, s2, s3;
    logic             tog_edge;
    logic [15:0]      phase;
    logic [GAP_W-1:0] gap;
    logic             count_en, lost_d, gap_clr, gap_inc;

    assign tog_edge = s2 ^ s3;

    always_comb begin
        state_d  = state;
        lost_d   = lost;
        count_en = 1'b0;
        gap_clr  = 1'b0;
        gap_inc  = 1'b0;
        case (state)
            IDLE: begin
                lost_d  = 1'b0;
                gap_clr = 1'b1;
                if (run) state_d = RUN;
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                    lost_d  = 1'b0;
                    gap_clr = 1'b1;
                end else if (tog_edge) begin
                    count_en = 1'b1;
                    gap_clr  = 1'b1;
                end else begin
                    gap_inc = 1'b1;
                    if (gap == GAP_W'(TIMEOUT_CYC - 1) && !clear) begin
                        state_d = LOST;
                        lost_d  = 1'b1;
                    end
                end
            end
            LOST: begin
                if (!run) begin
                    state_d = IDLE;
                    lost_d  = 1'b0;
                    gap_clr = 1'b1;
                end else if (tog_edge) begin
                    state_d  = RUN;
                    lost_d   = 1'b0;
                    count_en = 1'b1;
                    gap_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // clear swallows a coincident edge but leaves the state decision alone
        if (clear) begin
            count_en = 1'b0;
            gap_clr  = 1'b1;
            gap_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            ms_tick  <= 1'b0;
            ms_count <= '0;
            beat     <= 1'b0;
            beat_idx <= '0;
            lost     <= 1'b0;
            phase    <= '0;
            gap      <= '0;
            state    <= IDLE;
        end else begin
            s1      <= tog_in;
            s2      <= s1;
            s3      <= s2;
            ms_tick <= tog_edge;
            state   <= state_d;
            lost    <= lost_d;
            beat    <= 1'b0;

            if (gap_clr)                  gap <= '0;
            else if (gap_inc && gap != '1) gap <= gap + GAP_W'(1);

            if (clear) begin
                ms_count <= '0;
                phase    <= '0;
                beat_idx <= '0;
            end else if (beat_ms == '0) begin
                phase <= '0;
                if (count_en) ms_count <= ms_count + 32'd1;
            end else if (count_en) begin
                ms_count <= ms_count + 32'd1;
                // >= so a lowered period fires on the next edge instead of wrapping
                if (phase >= beat_ms - 16'd1) begin
                    phase    <= '0;
                    beat     <= 1'b1;
                    beat_idx <= beat_idx + 16'd1;
                end else begin
                    phase <= phase + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ms_tick_receiver.sv
// Self-checking bench for ms_tick_receiver: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the tick/beat/watchdog rules.
module tb_ms_tick_receiver;

    localparam int unsigned TOUT = 20;

    logic        clk = 1'b0;
    logic        rst_n, tog_in, run, clear;
    logic [15:0] beat_ms;
    logic        ms_tick, beat, lost;
    logic [31:0] ms_count;
    logic [15:0] beat_idx;

    int total = 0;
    int bad   = 0;

    ms_tick_receiver #(.TIMEOUT_CYC(TOUT), .GAP_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .run(run), .clear(clear),
        .beat_ms(beat_ms), .ms_tick(ms_tick), .ms_count(ms_count), .beat(beat),
        .beat_idx(beat_idx), .lost(lost)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    // Reference model: samples history of tog_in, counts edges per the ms/beat/lost rules.
    bit          h0, h1, h2, e;
    bit          m_tick, m_beat, m_lost, m_active, counted;
    int unsigned m_quiet;
    logic [31:0] m_count;
    logic [15:0] m_phase, m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 = 0; h1 = 0; h2 = 0;
            m_tick = 0; m_beat = 0; m_lost = 0; m_active = 0; m_quiet = 0;
            m_count = 0; m_phase = 0; m_idx = 0;
        end else begin
            e  = h1 ^ h2;
            h2 = h1; h1 = h0; h0 = tog_in;
            m_tick  = e;
            m_beat  = 0;
            counted = 0;
            if (!m_active) begin
                m_lost = 0; m_quiet = 0;
                if (run) m_active = 1;
            end else if (!run) begin
                m_active = 0; m_lost = 0; m_quiet = 0;
            end else if (e) begin
                counted = !clear; m_lost = 0; m_quiet = 0;
            end else if (!m_lost) begin
                m_quiet++;
                if (clear) m_quiet = 0;
                else if (m_quiet == TOUT) m_lost = 1;
            end
            if (clear) begin
                m_count = 0; m_phase = 0; m_idx = 0;
            end else begin
                if (counted) begin
                    m_count = m_count + 1;
                    if (beat_ms != 0) begin
                        if (int'(m_phase) + 1 >= int'(beat_ms)) begin
                            m_phase = 0; m_beat = 1; m_idx = m_idx + 1;
                        end else begin
                            m_phase = m_phase + 1;
                        end
                    end
                end
                if (beat_ms == 0) m_phase = 0;
            end
        end
    end

    task automatic pulse_clear();
        @(negedge clk); clear = 1;
        @(negedge clk); clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; tog_in = 0; run = 0; clear = 0; beat_ms = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({ms_tick, ms_count, beat, beat_idx, lost} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %0h want 0", {ms_tick, ms_count, beat, beat_idx, lost});
        end
        rst_n = 1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            total++;
            if (ms_tick !== (c == 13)) begin
                bad++; $display("FAIL idle_tick c=%0d: got %0b want %0b", c, ms_tick, c == 13);
            end
            if (c == 10) tog_in = ~tog_in;
        end
        total++;
        if (ms_count !== 32'd0) begin
            bad++; $display("FAIL idle_count: got %0d want 0", ms_count);
        end
    endtask

    task automatic test_beats();
        int nb = 0;
        run = 1; beat_ms = 4;
        pulse_clear();
        for (int i = 0; i < 12; i++) begin
            tog_in = ~tog_in;
            for (int w = 0; w < 6; w++) begin
                @(negedge clk);
                total++;
                if (ms_tick !== (w == 2) || beat !== ((w == 2) && (i % 4 == 3))) begin
                    bad++; $display("FAIL beat_timing i=%0d w=%0d: got tick=%0b beat=%0b want tick=%0b beat=%0b",
                                    i, w, ms_tick, beat, w == 2, (w == 2) && (i % 4 == 3));
                end
                total++;
                if (ms_count !== m_count) begin
                    bad++; $display("FAIL beat_count i=%0d: got %0d want %0d", i, ms_count, m_count);
                end
                if (beat) nb++;
            end
        end
        total++;
        if (ms_count !== 32'd12 || beat_idx !== 16'd3 || nb != 3) begin
            bad++; $display("FAIL beat_totals: got cnt=%0d idx=%0d beats=%0d want 12 3 3", ms_count, beat_idx, nb);
        end
    endtask

    task automatic test_lost();
        int n = 0;
        bit seen = 0;
        tog_in = ~tog_in;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (ms_tick) seen = 1;
        end
        total++;
        if (!seen || ms_count !== 32'd13) begin
            bad++; $display("FAIL lost_pre_tick: got seen=%0b cnt=%0d want 1 13", seen, ms_count);
        end
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (lost) seen = 1;
        end
        total++;
        if (!seen || n != 20) begin
            bad++; $display("FAIL lost_delay: got seen=%0b cycles=%0d want 1 20", seen, n);
        end
        tog_in = ~tog_in;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (lost !== 1'b1) begin
                bad++; $display("FAIL lost_hold: got %0b want 1", lost);
            end
        end
        @(negedge clk);
        total++;
        if (ms_tick !== 1'b1 || lost !== 1'b0 || ms_count !== 32'd14) begin
            bad++; $display("FAIL lost_recover: got tick=%0b lost=%0b cnt=%0d want 1 0 14", ms_tick, lost, ms_count);
        end
    endtask

    task automatic test_clear();
        beat_ms = 4;
        pulse_clear();
        for (int i = 0; i < 7; i++) begin
            tog_in = ~tog_in;
            repeat (6) @(negedge clk);
        end
        total++;
        if (ms_count !== 32'd7 || beat_idx !== 16'd1) begin
            bad++; $display("FAIL clear_pre: got cnt=%0d idx=%0d want 7 1", ms_count, beat_idx);
        end
        tog_in = ~tog_in;
        @(negedge clk);
        @(negedge clk); clear = 1;
        @(negedge clk);
        total++;
        if (ms_tick !== 1'b1 || beat !== 1'b0 || ms_count !== 32'd0 || beat_idx !== 16'd0 || dut.phase !== 16'd0) begin
            bad++; $display("FAIL clear_edge: got tick=%0b beat=%0b cnt=%0d idx=%0d ph=%0d want 1 0 0 0 0",
                            ms_tick, beat, ms_count, beat_idx, dut.phase);
        end
        clear = 0;
    endtask

    task automatic test_beat_change();
        beat_ms = 10;
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            tog_in = ~tog_in;
            repeat (6) @(negedge clk);
        end
        total++;
        if (dut.phase !== 16'd6 || beat_idx !== 16'd0) begin
            bad++; $display("FAIL bchg_pre: got ph=%0d idx=%0d want 6 0", dut.phase, beat_idx);
        end
        beat_ms = 3;
        for (int j = 0; j < 7; j++) begin
            tog_in = ~tog_in;
            for (int w = 0; w < 6; w++) begin
                @(negedge clk);
                if (w == 2) begin
                    total++;
                    if (beat !== (j % 3 == 0) || ms_tick !== 1'b1) begin
                        bad++; $display("FAIL bchg_beat j=%0d: got beat=%0b tick=%0b want %0b 1", j, beat, ms_tick, j % 3 == 0);
                    end
                end
            end
        end
        total++;
        if (beat_idx !== 16'd3) begin
            bad++; $display("FAIL bchg_idx: got %0d want 3", beat_idx);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.ms_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.ms_count;
        @(negedge clk);
        total++;
        if (ms_count !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_preload: got %0h want ffffffff", ms_count);
        end
        tog_in = ~tog_in;
        repeat (3) @(negedge clk);
        total++;
        if (ms_tick !== 1'b1 || ms_count !== 32'd0 || beat !== 1'b0 || beat_idx !== 16'd3 || lost !== 1'b0) begin
            bad++; $display("FAIL wrap_edge: got tick=%0b cnt=%0h beat=%0b idx=%0d lost=%0b want 1 0 0 3 0",
                            ms_tick, ms_count, beat, beat_idx, lost);
        end
    endtask

    task automatic test_random();
        int quiet_left = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            total++;
            if (ms_tick !== m_tick || beat !== m_beat || lost !== m_lost) begin
                bad++; $display("FAIL rnd_flags c=%0d: got %0b%0b%0b want %0b%0b%0b",
                                c, ms_tick, beat, lost, m_tick, m_beat, m_lost);
            end
            total++;
            if (ms_count !== m_count || beat_idx !== m_idx) begin
                bad++; $display("FAIL rnd_counts c=%0d: got %0d/%0d want %0d/%0d", c, ms_count, beat_idx, m_count, m_idx);
            end
            if (quiet_left > 0) quiet_left--;
            else if ($urandom_range(0, 60) == 0) quiet_left = $urandom_range(15, 35);
            else if ($urandom_range(0, 3) == 0) tog_in = ~tog_in;
            if ($urandom_range(0, 50) == 0) run = ~run;
            clear = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 40) == 0) beat_ms = 16'($urandom_range(0, 5));
        end
        clear = 0; run = 1;
    endtask

    task automatic test_reset_mid();
        beat_ms = 2;
        tog_in = ~tog_in;
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if ({ms_tick, ms_count, beat, beat_idx, lost} !== '0) begin
            bad++; $display("FAIL reset_mid: got %0h want 0", {ms_tick, ms_count, beat, beat_idx, lost});
        end
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (ms_tick !== m_tick || ms_count !== m_count) begin
                bad++; $display("FAIL reset_after c=%0d: got tick=%0b cnt=%0d want %0b %0d", c, ms_tick, ms_count, m_tick, m_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beats();
        test_lost();
        test_clear();
        test_beat_change();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
